// File: rtl/ps2_host_tx_pkg.sv
// Shared state encodings, PS/2 command bytes and small helpers for the host transmitter.
// Pure declarations; no timing or flow control of its own.
package ps2_host_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_REQ       = 3'd2;
  localparam state_t ST_SHIFT     = 3'd3;
  localparam state_t ST_ACK       = 3'd4;
  localparam state_t ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  // Device clock falls per frame: 8 data bits, parity, stop, then the ACK clock.
  localparam logic [3:0] FRAME_FALLS = 4'd11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side port bundle: byte + start request towards the transmitter, busy/done/err back.
// start is a single-cycle request honoured only while busy is low; done/err form a one-cycle result.
interface ps2_host_tx_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_byte, output tx_start, input busy, input done, input err);
  modport slave  (input tx_byte, input tx_start, output busy, output done, output err);
endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus FILTER_LEN run-length filter for one open-drain PS/2 line.
// Level changes 2+FILTER_LEN cycles after the pad; fall is a registered one-cycle pulse; no backpressure.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  // Lines idle high, so the filter starts at 1 and never reports a fall out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      run_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        level   <= sync2;
        run_cnt <= '0;
        fall    <= ~sync2;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Clock pull-down 1 cycle after accept; requests while busy are dropped; done/err pulse once per frame.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  ctl,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_drv_low,
  output logic          ps2_data_drv_low
);

  if (CLK_FREQ_HZ < 1 || INHIBIT_CYCLES < 1 || SETUP_CYCLES < 1 ||
      TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
    $error("ps2_host_tx: parameter out of range");
  end

  localparam int CNT_MAX = max_int(max_int(INHIBIT_CYCLES, SETUP_CYCLES), TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       tx_data;
  logic             parity;
  logic             nack;
  logic             clk_drv;
  logic             data_drv;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic clk_lvl;
  logic clk_fall;
  logic data_lvl;
  logic data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .pad   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .pad   (ps2_data_in),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_data  <= '0;
      parity   <= 1'b0;
      nack     <= 1'b0;
      clk_drv  <= 1'b0;
      data_drv <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ctl.tx_start) begin
            tx_data <= ctl.tx_byte;
            parity  <= odd_parity(ctl.tx_byte);
            clk_drv <= 1'b1;
            busy_r  <= 1'b1;
            cnt     <= '0;
            state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt      <= '0;
            data_drv <= 1'b1;
            state    <= ST_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REQ: begin
          // Releasing the clock with data held low is the request-to-send; data low doubles as the start bit.
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            clk_drv <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            cnt <= '0;
            if (bit_cnt != FRAME_FALLS) bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8)       data_drv <= ~tx_data[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8) data_drv <= ~parity;
            else if (bit_cnt == 4'd9) data_drv <= 1'b0;
            else                      state    <= ST_ACK;
          end else if (cnt >= TMO_LAST) begin
            clk_drv  <= 1'b0;
            data_drv <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            err_r    <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          nack  <= data_lvl;
          cnt   <= cnt + 1'b1;
          state <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (clk_lvl && data_lvl) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            err_r  <= nack;
            state  <= ST_IDLE;
          end else if (cnt >= TMO_LAST) begin
            clk_drv  <= 1'b0;
            data_drv <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            err_r    <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          clk_drv  <= 1'b0;
          data_drv <= 1'b0;
          busy_r   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_drv_low  = clk_drv;
  assign ps2_data_drv_low = data_drv;
  assign ctl.busy         = busy_r;
  assign ctl.done         = done_r;
  assign ctl.err          = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the host; a scoreboard
// checks every done against the expected frame/err queued when the command was issued.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 120;
  localparam int SET  = 10;
  localparam int TMO  = 3000;
  localparam int FLEN = 8;
  localparam int LOW  = 20;
  localparam int HIGH = 20;

  typedef struct {
    logic        err;
    logic        has_frame;
    logic [10:0] frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_drv;
  logic        data_drv;
  logic        dev_clk_low;
  logic        dev_data_low;
  logic        glitch;
  logic        ps2_clk_pad;
  logic        ps2_data_pad;
  logic [10:0] cap_frame;
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  ps2_host_tx_if ctl();

  assign ps2_clk_pad  = ~(clk_drv | dev_clk_low | glitch);
  assign ps2_data_pad = ~(data_drv | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ   (100_000_000),
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ctl             (ctl),
    .ps2_clk_in      (ps2_clk_pad),
    .ps2_data_in     (ps2_data_pad),
    .ps2_clk_drv_low (clk_drv),
    .ps2_data_drv_low(data_drv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line levels the device sees: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Scoreboard: every done must match the oldest queued expectation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin : mon_done
    exp_t e;
    if (!rst && ctl.done === 1'b1) begin
      done_cnt++;
      check("done_pulse", done_prev, 0);
      check("busy_at_done", ctl.busy, 0);
      check("drv_at_done", {clk_drv, data_drv}, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with err=%0b, expected none", ctl.err);
      end else begin
        e = exp_q.pop_front();
        check("err", ctl.err, e.err);
        if (e.has_frame) check("frame", cap_frame, e.frame);
      end
    end
    done_prev = rst ? 1'b0 : ctl.done;
  end

  // Request phase shape: clock held INH+SET cycles, data joins for the last SET of them.
  int   clk_run = 0;
  int   both_run = 0;
  logic clk_prev = 1'b0;
  always @(negedge clk) begin : mon_req
    if (rst) begin
      clk_run  = 0;
      both_run = 0;
    end else if (clk_drv === 1'b1) begin
      clk_run++;
      if (data_drv === 1'b1) both_run++;
    end else if (clk_prev === 1'b1) begin
      check("clk_low_len", clk_run, INH + SET);
      check("data_lead", both_run, SET);
      clk_run  = 0;
      both_run = 0;
    end
    clk_prev = rst ? 1'b0 : clk_drv;
  end

  task automatic issue(input logic [7:0] b);
    ctl.tx_byte  = b;
    ctl.tx_start = 1'b1;
    @(negedge clk);
    ctl.tx_start = 1'b0;
    check("accept_clk_drv", clk_drv, 1);
    check("accept_busy", ctl.busy, 1);
  endtask

  task automatic wait_release(output bit ok);
    int n = 0;
    while (clk_drv === 1'b1 && n < INH + SET + 20) begin
      @(negedge clk);
      n++;
    end
    ok = (clk_drv === 1'b0);
    check("release", ok, 1);
  endtask

  task automatic device(input bit ack, input bit do_glitch);
    cap_frame = '0;
    repeat (10) @(negedge clk);
    cap_frame[0] = ps2_data_pad;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (LOW) @(negedge clk);
      dev_clk_low  = 1'b0;
      cap_frame[k] = ps2_data_pad;
      if (do_glitch && k == 4) begin
        repeat (5) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (HIGH - 8) @(negedge clk);
      end else begin
        repeat (HIGH) @(negedge clk);
      end
    end
    dev_data_low = ack;
    repeat (HIGH) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (LOW) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < TMO + 500) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic transact(input logic [7:0] b, input bit ack, input bit do_glitch);
    bit ok;
    exp_q.push_back('{err: ~ack, has_frame: 1'b1, frame: ref_frame(b)});
    issue(b);
    wait_release(ok);
    if (ok) device(ack, do_glitch);
    drain("drain");
    repeat (5) @(negedge clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit         ok;
    int         n;
    int         done_snap;
    logic [7:0] b;
    rst          = 1'b1;
    ctl.tx_start = 1'b0;
    ctl.tx_byte  = '0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    glitch       = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_clk_drv", clk_drv, 0);
    check("rst_data_drv", data_drv, 0);
    check("rst_busy", ctl.busy, 0);
    check("rst_done", ctl.done, 0);
    check("rst_err", ctl.err, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    transact(PS2_CMD_SET_LED, 1'b1, 1'b0);
    transact(PS2_CMD_RESET, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      transact(b, $urandom_range(0, 3) != 0, i == 2);
    end

    // A second request while busy must be dropped, not queued or relatched.
    exp_q.push_back('{err: 1'b0, has_frame: 1'b1, frame: ref_frame(8'h5A)});
    issue(8'h5A);
    repeat (20) @(negedge clk);
    ctl.tx_byte  = 8'hA5;
    ctl.tx_start = 1'b1;
    @(negedge clk);
    ctl.tx_start = 1'b0;
    wait_release(ok);
    if (ok) device(1'b1, 1'b0);
    drain("drain_busy");
    repeat (50) @(negedge clk);
    check("no_requeue_busy", ctl.busy, 0);
    check("no_requeue_clk", clk_drv, 0);

    // Silent device: timeout counted from clock release.
    exp_q.push_back('{err: 1'b1, has_frame: 1'b0, frame: '0});
    issue(PS2_CMD_ENABLE);
    wait_release(ok);
    n = 0;
    while (ctl.done !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_len", n, TMO);
    drain("drain_timeout");
    repeat (5) @(negedge clk);

    // Reset in the middle of the shift phase abandons the frame silently.
    issue(8'h00);
    wait_release(ok);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1;
      repeat (LOW) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HIGH) @(negedge clk);
    end
    check("pre_rst_data_drv", data_drv, 1);
    done_snap = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_clk_drv", clk_drv, 0);
    check("mid_rst_data_drv", data_drv, 0);
    check("mid_rst_busy", ctl.busy, 0);
    check("mid_rst_done", ctl.done, 0);
    check("mid_rst_err", ctl.err, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("no_done_after_rst", done_cnt, done_snap);

    // Reset and start together: reset wins.
    rst          = 1'b1;
    ctl.tx_byte  = PS2_CMD_SET_LED;
    ctl.tx_start = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    ctl.tx_start = 1'b0;
    check("rst_start_busy", ctl.busy, 0);
    check("rst_start_clk_drv", clk_drv, 0);
    repeat (5) @(negedge clk);
    check("rst_start_idle", ctl.busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
